// File: rtl/fetch_sequencer.sv
// Program-counter sequencer feeding the instruction fetch unit.
// Issues one-cycle fetch strobes, captures the returned word and hands it
// to decode over valid/ready, and drops responses made stale by a redirect.
//
//   state | meaning
//   IDLE  | no fetch outstanding, nothing held; issues when enabled
//   WAIT  | one fetch outstanding; discard marks it stale
//   HOLD  | instruction presented to decode, waiting for out_ready
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        s_aclk,
  input  logic        s_areset,
  input  logic        enable,
  output logic        fetch,
  output logic [31:0] address,
  input  logic        fetch_done,
  input  logic [31:0] instruction_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic        fetch_nxt;
  logic [31:0] address_nxt;
  logic        out_valid_nxt;
  logic [31:0] out_instr_nxt, out_pc_nxt, instr_count_nxt;
  logic [31:0] redirect_pc_aligned;
  logic [31:0] pc_inc;

  assign redirect_pc_aligned = redirect_pc & ~32'd3;
  assign pc_inc              = pc + 32'd4;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state       <= IDLE;
      pc          <= RESET_PC_ALIGNED;
      discard     <= 1'b0;
      fetch       <= 1'b0;
      address     <= RESET_PC_ALIGNED;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_pc      <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      discard     <= discard_nxt;
      fetch       <= fetch_nxt;
      address     <= address_nxt;
      out_valid   <= out_valid_nxt;
      out_instr   <= out_instr_nxt;
      out_pc      <= out_pc_nxt;
      instr_count <= instr_count_nxt;
    end
  end

  // Next-state and next-output logic; redirect outranks everything in every state.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    discard_nxt     = discard;
    fetch_nxt       = 1'b0;
    address_nxt     = address;
    out_valid_nxt   = out_valid;
    out_instr_nxt   = out_instr;
    out_pc_nxt      = out_pc;
    instr_count_nxt = instr_count;

    case (state)
      IDLE: begin
        if (redirect) begin
          pc_nxt        = redirect_pc_aligned;
          out_valid_nxt = 1'b0;
        end else if (enable) begin
          fetch_nxt   = 1'b1;
          address_nxt = pc;
          state_nxt   = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_nxt        = redirect_pc_aligned;
          out_valid_nxt = 1'b0;
          if (fetch_done) begin
            // The response in flight has just arrived and is dropped, so
            // nothing is outstanding any more: go idle rather than keep waiting.
            discard_nxt = 1'b0;
            state_nxt   = IDLE;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (fetch_done) begin
          if (discard) begin
            discard_nxt = 1'b0;
            if (enable) begin
              fetch_nxt   = 1'b1;
              address_nxt = pc;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            out_instr_nxt = instruction_in;
            out_pc_nxt    = pc;
            out_valid_nxt = 1'b1;
            state_nxt     = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_nxt        = redirect_pc_aligned;
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (out_ready) begin
          out_valid_nxt   = 1'b0;
          instr_count_nxt = instr_count + 32'd1;
          pc_nxt          = pc_inc;
          if (enable) begin
            fetch_nxt   = 1'b1;
            address_nxt = pc_inc;
            state_nxt   = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised scoreboard bench for fetch_sequencer. A fetch-unit responder
// answers each request after a random latency with address^A5A5A5A5; the
// reference model tracks the architectural PC and which responses must
// reach decode, pushing expected handoffs into a queue that an independent
// monitor pops on every accepted handoff.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC_MAIN = 32'h0000_0000;
  localparam logic [31:0] SALT          = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, fetch, fetch_done, redirect, out_valid, out_ready;
  logic [31:0] address, instruction_in, redirect_pc, out_instr, out_pc, instr_count;

  logic        rst2, en2, fetch2, fd2, redir2, out_valid2, rdy2;
  logic [31:0] address2, ir2, rpc2, out_instr2, out_pc2, instr_count2;

  fetch_sequencer #(.RESET_PC(RESET_PC_MAIN)) dut (
    .s_aclk(clk), .s_areset(rst), .enable(enable), .fetch(fetch), .address(address),
    .fetch_done(fetch_done), .instruction_in(instruction_in), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .instr_count(instr_count)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .s_aclk(clk), .s_areset(rst2), .enable(en2), .fetch(fetch2), .address(address2),
    .fetch_done(fd2), .instruction_in(ir2), .redirect(redir2),
    .redirect_pc(rpc2), .out_valid(out_valid2), .out_ready(rdy2),
    .out_instr(out_instr2), .out_pc(out_pc2), .instr_count(instr_count2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  item_t       e_item;
  int          total = 0;
  int          bad = 0;

  // reference model
  logic [31:0] pc_model = RESET_PC_MAIN;
  int          cnt_model = 0;
  logic [31:0] last_out_pc = 32'd0;

  // fetch-unit responder: at most one outstanding request
  logic        pend_valid = 1'b0, pend_stale = 1'b0, pend_rst = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_left = 0;

  // stimulus knobs
  int          k_en = 0, k_rdy = 100, k_redir = 0, k_rst_pm = 0;
  int          k_lat_min = 3, k_lat_max = 3;
  bit          k_spacing = 1'b0;
  int          force_mode = 0;
  logic [31:0] force_rpc = 32'd0;
  int          cyc = 0;
  int          last_fetch_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  // One clock of stimulus: responder first, then new inputs for this cycle.
  task automatic step();
    logic        fire, f_stale, do_redir, do_rst;
    logic [31:0] f_addr;
    int          lat;
    @(posedge clk);
    #1;
    cyc++;
    fire = 1'b0; f_stale = 1'b0; f_addr = 32'd0;
    if (pend_valid) begin
      if (pend_left <= 1) begin
        fire = 1'b1; f_addr = pend_addr; f_stale = pend_stale; pend_valid = 1'b0;
      end else begin
        pend_left--;
      end
    end
    if (fetch) begin
      chk("fetch_address", address, pc_model);
      chk("fetch_overlap", {31'd0, pend_valid | fire}, 32'd0);
      // request edge to response edge is lat+1, plus one edge in HOLD
      if (k_spacing && last_fetch_cyc >= 0)
        chk("fetch_spacing", cyc - last_fetch_cyc, k_lat_max + 2);
      last_fetch_cyc = cyc;
      lat = int'($urandom_range(k_lat_max, k_lat_min));
      pend_valid = 1'b1; pend_addr = address; pend_left = lat;
      pend_stale = 1'b0; pend_rst = 1'b0;
    end
    do_rst      = ($urandom_range(999) < k_rst_pm);
    do_redir    = ($urandom_range(99) < k_redir);
    redirect_pc = ($urandom_range(3) == 0) ? 32'h0000_1003 : $urandom();
    case (force_mode)
      1: if (pend_valid) begin do_redir = 1'b1; do_rst = 1'b0; redirect_pc = force_rpc; force_mode = 0; end
      2: if (fire) begin do_redir = 1'b1; do_rst = 1'b0; redirect_pc = force_rpc; force_mode = 0; end
      3: if (out_valid) begin do_redir = 1'b1; do_rst = 1'b0; redirect_pc = force_rpc; force_mode = 0; end
      4: if (pend_valid) begin do_rst = 1'b1; force_mode = 0; end
      default: ;
    endcase
    rst       = do_rst;
    redirect  = do_redir;
    // after a reset, hold enable low until the pre-reset response has landed
    enable    = ($urandom_range(99) < k_en) && !(pend_valid && pend_rst);
    out_ready = ($urandom_range(99) < k_rdy);
    if (fire) begin
      fetch_done     = 1'b1;
      instruction_in = f_addr ^ SALT;
      if (!f_stale && !do_redir && !do_rst) exp_q.push_back('{f_addr, f_addr ^ SALT});
    end else begin
      fetch_done     = 1'b0;
      instruction_in = $urandom();
    end
    if (pend_valid && (do_redir || do_rst)) pend_stale = 1'b1;
    if (pend_valid && do_rst) pend_rst = 1'b1;
    if (do_rst) begin
      pc_model = RESET_PC_MAIN & ~32'd3;
      exp_q.delete();
    end else if (do_redir) begin
      pc_model = redirect_pc & ~32'd3;
      exp_q.delete();
    end
  endtask

  task automatic wait_force(input string name);
    int g = 0;
    while (force_mode != 0 && g < 100) begin step(); g++; end
    if (force_mode != 0) begin timeout_fail(name); force_mode = 0; end
  endtask

  task automatic wait_handoffs(input string name, input int target);
    int g = 0;
    while (cnt_model < target && g < 200) begin step(); g++; end
    if (cnt_model < target) timeout_fail(name);
  endtask

  // Monitor: sample mid-cycle, pop the scoreboard on each accepted handoff.
  logic        hold_prev = 1'b0;
  logic [31:0] pc_prev = 32'd0, instr_prev = 32'd0;
  always @(negedge clk) begin
    chk("instr_count", instr_count, cnt_model);
    if (hold_prev) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_pc", out_pc, pc_prev);
      chk("hold_instr", out_instr, instr_prev);
      chk("hold_no_fetch", {31'd0, fetch}, 32'd0);
    end
    hold_prev  = out_valid && !out_ready && !redirect && !rst;
    pc_prev    = out_pc;
    instr_prev = out_instr;
    if (rst) begin
      cnt_model = 0;
    end else if (out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_handoff actual_pc=%h required=none", out_pc);
      end else begin
        e_item = exp_q.pop_front();
        chk("handoff_pc", out_pc, e_item.pc);
        chk("handoff_instr", out_instr, e_item.instr);
      end
      last_out_pc = out_pc;
      cnt_model++;
      pc_model = pc_model + 32'd4;
    end
  end

  initial begin
    int cnt_d;
    int g;
    rst = 1'b1; enable = 1'b0; fetch_done = 1'b0; instruction_in = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; fd2 = 1'b0; ir2 = 32'd0; redir2 = 1'b0; rpc2 = 32'd0; rdy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_fetch", {31'd0, fetch}, 32'd0);
    chk("reset_address", address, 32'h0000_0000);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_instr_count", instr_count, 32'd0);

    // straight-line fetching, fixed latency, decode always ready
    k_en = 100; k_rdy = 100; k_lat_min = 3; k_lat_max = 3; k_spacing = 1'b1;
    wait_handoffs("four_handoffs", 4);
    step();
    chk("count_after_4", instr_count, 32'd4);
    k_spacing = 1'b0;

    // decode stalls; monitor checks HOLD stability
    k_rdy = 0;
    repeat (12) step();
    k_rdy = 100;
    wait_handoffs("after_stall", cnt_model + 1);

    // redirect while a fetch is outstanding
    k_lat_min = 2; k_lat_max = 4;
    force_rpc = 32'h0000_1003; force_mode = 1;
    wait_force("redirect_in_wait");
    wait_handoffs("redirect_first", cnt_model + 1);
    chk("redirect_first_pc", last_out_pc, 32'h0000_1000);

    // redirect together with fetch_done, then redirect in HOLD with ready high
    force_rpc = 32'h2000_0041; force_mode = 2;
    wait_force("redirect_on_done");
    cnt_d = cnt_model;
    force_rpc = 32'h3000_000A; force_mode = 3;
    wait_force("redirect_in_hold");
    step();
    chk("drop_count", instr_count, cnt_d);
    wait_handoffs("after_drops", cnt_d + 1);
    chk("after_drops_pc", last_out_pc, 32'h3000_0008);

    // random mix of everything
    k_en = 80; k_rdy = 60; k_redir = 8; k_rst_pm = 5; k_lat_min = 1; k_lat_max = 4;
    repeat (3000) step();

    // reset while waiting; stale response lands in IDLE with enable low
    k_redir = 0; k_rst_pm = 0; k_en = 100; k_lat_min = 3; k_lat_max = 3;
    force_mode = 4;
    wait_force("reset_in_wait");
    k_en = 0;
    repeat (6) step();
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_out_pc", out_pc, 32'd0);
    chk("post_rst_out_instr", out_instr, 32'd0);
    chk("post_rst_count", instr_count, 32'd0);
    chk("post_rst_fetch", {31'd0, fetch}, 32'd0);
    chk("post_rst_address", address, 32'h0000_0000);

    k_rdy = 100;
    repeat (10) step();
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // wrap of the PC from the top of the address space
    rst2 = 1'b0; en2 = 1'b1; rdy2 = 1'b1;
    g = 0;
    do begin @(posedge clk); #1; g++; end while (!fetch2 && g < 10);
    chk("wrap_fetch1", {31'd0, fetch2}, 32'd1);
    chk("wrap_addr1", address2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fd2 = 1'b1; ir2 = 32'hFFFF_FFFC ^ SALT;
    @(posedge clk); #1;
    fd2 = 1'b0;
    chk("wrap_valid", {31'd0, out_valid2}, 32'd1);
    chk("wrap_out_pc", out_pc2, 32'hFFFF_FFFC);
    chk("wrap_out_instr", out_instr2, 32'hFFFF_FFFC ^ SALT);
    @(posedge clk); #1;
    en2 = 1'b0;
    chk("wrap_fetch2", {31'd0, fetch2}, 32'd1);
    chk("wrap_addr2", address2, 32'h0000_0000);
    chk("wrap_count", instr_count2, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
